line_buffer_ctrl: RTL
=====================

// Module: line_buffer_ctrl
// PURPOSE
//  Sequencer for the three line RAM banks that feed the 3x3 window builder (line1/line2/line3).
//  Tracks the video stream (vsync/hsync/de) and generates the RAM write strobe, write bank and
//  pixel address. Rotates banks at every line end, and publishes which bank is the oldest,
//  middle and newest row. Asserts mat_de only once two full rows are buffered, aligned to RAM read latency.
// PARAMETERS
//  H_ACT   1280  active pixels per line; address width AW=$clog2(H_ACT)
//  V_ACT   720   active lines per frame; row counter width VW=$clog2(V_ACT)
//  RD_LAT  1     line-RAM read latency in cycles (1..4); mat_de/mat_x delayed by this
// PORTS
//  clk        in   1    pixel clock (from hdmi_unpack)
//  rst        in   1    synchronous reset, active-high
//  vsync      in   1    frame sync, active-high; rising edge = frame start
//  hsync      in   1    line sync; informational only, not used for sequencing
//  de         in   1    active pixel strobe
//  wr_en      out  1    line-RAM write strobe (comb: de & state!=IDLE & !addr_full)
//  wr_bank    out  2    bank index 0..2 written this line
//  addr       out  AW   shared write/read pixel address (read-before-write)
//  bank_l1    out  2    bank holding oldest row (-> line1)
//  bank_l2    out  2    bank holding middle row (-> line2)
//  bank_l3    out  2    bank = wr_bank (live row -> line3)
//  row_cnt    out  VW   completed rows this frame, saturates at V_ACT-1
//  mat_de     out  1    window column valid, RD_LAT cycles after qualifying de
//  mat_x      out  AW   addr delayed by RD_LAT, paired with mat_de
//  err_long   out  1    sticky overlong-line flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, wr_bank=0, addr=0, row_cnt=0, bank_l1=1, bank_l2=2,
//   delay pipe cleared (mat_de=0, mat_x=0), err_long=0; wr_en=0 since state=IDLE. Mid-frame reset
//   discards the frame; the block resumes at the next vsync rise.
//  States: IDLE -> FILL on vsync rise; FILL -> RUN at end of the line that makes row_cnt==2;
//   any state -> FILL on vsync rise: addr=0, row_cnt=0, wr_bank=0, bank_l1=1, bank_l2=2.
//   RUN holds until vsync rise or rst. No exit from IDLE except vsync rise.
//  Edges: vsync/de edges use registered previous values; line end = de 1->0 (de_q=1, de=0).
//  addr: +1 each cycle de=1; saturates at H_ACT-1 (addr_full, wr_en forced 0);
//   returns to 0 on the cycle after line end.
//  Line end (state!=IDLE): bank_l1<=bank_l2, bank_l2<=wr_bank,
//   wr_bank<=(wr_bank==2)?0:wr_bank+1; row_cnt+1 (saturating).
//  Rotation invariant: {bank_l1,bank_l2,wr_bank} is always a permutation of {0,1,2}.
//  mat_de: delay RD_LAT of (de & state==RUN & !addr_full). mat_x is delayed with it.
//  Simultaneous vsync rise and line end: vsync wins; counters and banks re-init; no rotation.
//  de high in IDLE: ignored; no write, addr stays 0.
//  A vsync rise while mat_de is in flight flushes the delay pipe to 0.
// CONFIGURATION
//  `LINE_BUFFER_CTRL_ERR_EN defined: err_long set when de=1 with addr_full=1.
//   err_long is sticky and cleared only by rst or a vsync rise.
//  Not defined: err_long tied 0; no detection logic. Saturation behaviour is unchanged either way.
// TESTING (H_ACT=8, V_ACT=6, RD_LAT=1 unless noted)
//  1 rst 3 cycles, then de pulses with no vsync -> wr_en=0, addr=0, mat_de=0 throughout.
//  2 vsync rise, 3 lines of 8-cycle de -> wr_bank 0,1,2; at line-3 start bank_l1=0, bank_l2=1;
//    mat_de first high 1 cycle after line-3 de rises; mat_x=0..7.
//  3 6 lines then vsync rise coincident with line-6 de fall -> row_cnt=0, wr_bank=0,
//    state=FILL, no rotation.
//  4 line with 10-cycle de -> addr sticks at 7, wr_en=0 for last 2 cycles;
//    err_long=1 with macro, 0 without; cleared at next vsync rise.
//  5 rst asserted mid-line in RUN -> next cycle all outputs at reset values;
//    de ignored until vsync rise.
//  6 RD_LAT=3: repeat test 2 -> mat_de/mat_x lag de by exactly 3 cycles;
//    vsync rise mid-pipe clears mat_de.

Source files
------------

// File: rtl/line_buffer_ctrl_if.sv
// Video-in / line-RAM-control bundle for line_buffer_ctrl.
// slave = controller side, master = video source / RAM side.
interface line_buffer_ctrl_if #(
  parameter int AW = 11,
  parameter int VW = 10
);
  logic          vsync;
  logic          hsync;
  logic          de;
  logic          wr_en;
  logic [1:0]    wr_bank;
  logic [AW-1:0] addr;
  logic [1:0]    bank_l1;
  logic [1:0]    bank_l2;
  logic [1:0]    bank_l3;
  logic [VW-1:0] row_cnt;
  logic          mat_de;
  logic [AW-1:0] mat_x;
  logic          err_long;

  modport master (
    output vsync, hsync, de,
    input  wr_en, wr_bank, addr,
    input  bank_l1, bank_l2, bank_l3,
    input  row_cnt, mat_de, mat_x, err_long
  );

  modport slave (
    input  vsync, hsync, de,
    output wr_en, wr_bank, addr,
    output bank_l1, bank_l2, bank_l3,
    output row_cnt, mat_de, mat_x, err_long
  );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Line-RAM sequencer for a 3x3 window: write strobe/bank/address,
// bank rotation per line, row count, and RD_LAT-aligned mat_de/mat_x.
// Ports: clk, rst (sync, active-high), bus (line_buffer_ctrl_if.slave):
//   in vsync/hsync/de; out wr_en, wr_bank, addr, bank_l1..l3,
//   row_cnt, mat_de, mat_x, err_long.
// Option: define LINE_BUFFER_CTRL_ERR_EN for sticky overlong-line flag.
module line_buffer_ctrl #(
  parameter int H_ACT  = 1280,
  parameter int V_ACT  = 720,
  parameter int RD_LAT = 1,
  localparam int AW = $clog2(H_ACT),
  localparam int VW = $clog2(V_ACT)
) (
  input logic                clk,
  input logic                rst,
  line_buffer_ctrl_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [AW-1:0] ADDR_MAX = AW'(H_ACT - 1);
  localparam logic [VW-1:0] ROW_MAX  = VW'(V_ACT - 1);
  localparam logic [VW-1:0] ROW_ONE  = VW'(1);

  logic [1:0]    r_state;
  logic          r_vs_q;
  logic          r_de_q;
  logic          r_full;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_wr_bank;
  logic [1:0]    r_l1;
  logic [1:0]    r_l2;
  logic [VW-1:0] r_row;
  logic          r_pde [RD_LAT];
  logic [AW-1:0] r_px  [RD_LAT];
  logic          r_err;

  logic w_act;
  logic w_vs_rise;
  logic w_line_end;
  logic w_wr;
  logic w_qual;
  logic w_unused_hsync;

  assign w_unused_hsync = bus.hsync;

  assign w_act      = (r_state != S_IDLE);
  assign w_vs_rise  = bus.vsync & ~r_vs_q;
  assign w_line_end = r_de_q & ~bus.de & w_act;
  // r_full marks that the last address was already written.
  assign w_wr       = bus.de & w_act & ~r_full;
  assign w_qual     = w_wr & (r_state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_q <= 1'b0;
      r_de_q <= 1'b0;
    end else begin
      r_vs_q <= bus.vsync;
      r_de_q <= bus.de;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_full    <= 1'b0;
      r_addr    <= '0;
      r_wr_bank <= 2'd0;
      r_l1      <= 2'd1;
      r_l2      <= 2'd2;
      r_row     <= '0;
    end else if (w_vs_rise) begin
      r_state   <= S_FILL;
      r_full    <= 1'b0;
      r_addr    <= '0;
      r_wr_bank <= 2'd0;
      r_l1      <= 2'd1;
      r_l2      <= 2'd2;
      r_row     <= '0;
    end else if (w_line_end) begin
      r_addr    <= '0;
      r_full    <= 1'b0;
      r_l1      <= r_l2;
      r_l2      <= r_wr_bank;
      r_wr_bank <= (r_wr_bank == 2'd2) ? 2'd0
                                       : r_wr_bank + 2'd1;
      if (r_row != ROW_MAX)
        r_row <= r_row + ROW_ONE;
      // second completed row: two rows now buffered
      if (r_state == S_FILL && r_row == ROW_ONE)
        r_state <= S_RUN;
    end else if (w_wr) begin
      if (r_addr == ADDR_MAX)
        r_full <= 1'b1;
      else
        r_addr <= r_addr + AW'(1);
    end
  end

  // Read-latency alignment pipe; a new frame discards it.
  always_ff @(posedge clk) begin
    if (rst || w_vs_rise) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pde[i] <= 1'b0;
        r_px[i]  <= '0;
      end
    end else begin
      r_pde[0] <= w_qual;
      r_px[0]  <= r_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pde[i] <= r_pde[i-1];
        r_px[i]  <= r_px[i-1];
      end
    end
  end

`ifdef LINE_BUFFER_CTRL_ERR_EN
  always_ff @(posedge clk) begin
    if (rst || w_vs_rise)
      r_err <= 1'b0;
    else if (bus.de && r_full)
      r_err <= 1'b1;
  end
`else
  assign r_err = 1'b0;
`endif

  assign bus.wr_en    = w_wr;
  assign bus.wr_bank  = r_wr_bank;
  assign bus.addr     = r_addr;
  assign bus.bank_l1  = r_l1;
  assign bus.bank_l2  = r_l2;
  assign bus.bank_l3  = r_wr_bank;
  assign bus.row_cnt  = r_row;
  assign bus.mat_de   = r_pde[RD_LAT-1];
  assign bus.mat_x    = r_px[RD_LAT-1];
  assign bus.err_long = r_err;
endmodule
